sha_msg_sched: RTL and testbench

SHA-256 message schedule stage for the sha_hashing datapath.
- Accepts one 512-bit block as 16 serial 32-bit words.
- Then produces W[t] for rounds t=0..63, one word per round.
- Round advance is driven by the same enable that steps the round counter. The counter's count output (round address) is consumed for cross-checking.
- Sits between the block-input interface and the compression round logic; W[t] is paired with K[count] downstream.

---
 rtl/sha_msg_sched_if.sv | 27 ++
 rtl/sha_msg_sched.sv | 113 +++++++++++
 tb/tb_sha_msg_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_msg_sched_if.sv
// sha_msg_sched_if: block-load and round-schedule signals of the SHA-256
// message schedule stage. master = block source / round control side,
// slave = schedule stage.
interface sha_msg_sched_if #(
  parameter int WORD_W   = 32,
  parameter int CNT_SIZE = 6
);
  logic                i_load_valid;
  logic                o_load_ready;
  logic [WORD_W-1:0]   i_load_word;
  logic                i_cnt_en;
  logic [CNT_SIZE-1:0] i_count;
  logic                o_w_valid;
  logic [WORD_W-1:0]   o_w;
  logic                o_sched_done;
  logic                o_round_err;

  modport master (
    output i_load_valid, i_load_word, i_cnt_en, i_count,
    input  o_load_ready, o_w_valid, o_w, o_sched_done, o_round_err
  );

  modport slave (
    input  i_load_valid, i_load_word, i_cnt_en, i_count,
    output o_load_ready, o_w_valid, o_w, o_sched_done, o_round_err
  );
endinterface

// File: rtl/sha_msg_sched.sv
// sha_msg_sched: SHA-256 message schedule. Loads 16 words of a block, then
// emits W[t] for t=0..63, one per round advance (i_cnt_en), using a 16-word
// sliding window. Optional macro ROUND_CHK_EN builds a sticky round-index
// cross-check against the external counter (o_round_err); without it the
// flag is tied low.
module sha_msg_sched #(
  parameter int WORD_W   = 32,
  parameter int ROUNDS   = 64,
  parameter int CNT_SIZE = 6
) (
  input logic          clk,
  input logic          reset_n,
  sha_msg_sched_if.slave bus
);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t              state;
  logic [3:0]          idx;
  logic [CNT_SIZE-1:0] t;
  logic [WORD_W-1:0]   window [16];
  logic                done;
  logic [WORD_W-1:0]   new_word;
  logic                accept;
  logic                advance;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign bus.o_load_ready = reset_n && (state == LOAD);
  assign accept           = bus.i_load_valid && bus.o_load_ready;
  assign advance          = (state == RUN) && bus.i_cnt_en;
  assign bus.o_w_valid    = (state == RUN);
  assign bus.o_w          = (state == RUN) ? window[0] : '0;
  assign bus.o_sched_done = done;

  // Next schedule word entering the top of the window
  always_comb begin
    new_word = ssig1(window[14]) + window[9] + ssig0(window[1]) + window[0];
  end

  // Load / run / done sequencing with window storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= LOAD;
      idx   <= '0;
      t     <= '0;
      done  <= 1'b0;
      for (int unsigned k = 0; k < 16; k++) window[k] <= '0;
    end else begin
      case (state)
        LOAD: begin
          done <= 1'b0;
          if (accept) begin
            window[idx] <= bus.i_load_word;
            if (idx == 4'd15) begin
              idx   <= '0;
              t     <= '0;
              state <= RUN;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        RUN: begin
          if (bus.i_cnt_en) begin
            for (int unsigned k = 0; k < 15; k++) window[k] <= window[k+1];
            window[15] <= new_word;
            if (t == CNT_SIZE'(ROUNDS - 1)) begin
              t     <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          state <= LOAD;
        end
      endcase
    end
  end

`ifdef ROUND_CHK_EN
  logic round_err;

  assign bus.o_round_err = round_err;

  // Sticky round mismatch; a new block's first accepted word clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_err <= 1'b0;
    end else if (accept && (idx == 4'd0)) begin
      round_err <= 1'b0;
    end else if (advance && (bus.i_count != t)) begin
      round_err <= 1'b1;
    end
  end
`else
  logic unused_round_chk;

  assign bus.o_round_err = 1'b0;
  assign unused_round_chk = advance ^ (^bus.i_count);
`endif

endmodule

// File: tb/tb_sha_msg_sched.sv
// tb_sha_msg_sched: randomized bench for sha_msg_sched against a reference
// schedule computed from the SHA-256 recurrence over a 64-entry array.
module tb_sha_msg_sched;

  logic clk;
  logic reset_n;

  sha_msg_sched_if #(.WORD_W(32), .CNT_SIZE(6)) bus ();

  sha_msg_sched #(.WORD_W(32), .ROUNDS(64), .CNT_SIZE(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int fails  = 0;
  int t      = 0;
  bit exp_err = 1'b0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  function automatic void compute_model();
    logic [31:0] s0, s1;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) exp_w[i] = blk[i];
      else begin
        s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
        s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
        exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
      end
    end
  endfunction

  function automatic void set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    compute_model();
  endfunction

  function automatic void set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    compute_model();
  endfunction

  // Feed the 16 block words with random valid gaps; ends at the first RUN cycle
  task automatic load_block(input int valid_pct);
    int n   = 0;
    int cyc = 0;
    while (n < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (n > 0) exp_err = 1'b0;
      checks++;
      if (bus.o_load_ready !== 1'b1 || bus.o_w_valid !== 1'b0 || bus.o_round_err !== exp_err) begin
        fails++;
        $display("FAIL load_state n=%0d: ready=%b valid=%b err=%b, want ready=1 valid=0 err=%b",
                 n, bus.o_load_ready, bus.o_w_valid, bus.o_round_err, exp_err);
      end
      bus.i_load_valid = ($urandom_range(99) < valid_pct);
      bus.i_load_word  = bus.i_load_valid ? blk[n] : $urandom;
      bus.i_cnt_en     = $urandom_range(1);
      bus.i_count      = 6'($urandom);
      #1;
      if (bus.i_load_valid && bus.o_load_ready) n++;
    end
    checks++;
    if (n < 16) begin
      fails++;
      $display("FAIL load_timeout: accepted=%0d, want 16", n);
    end
    exp_err = 1'b0;
    @(negedge clk);
    bus.i_load_valid = 1'b0;
    bus.i_cnt_en     = 1'b0;
    checks++;
    if (bus.o_w_valid !== 1'b1 || bus.o_load_ready !== 1'b0) begin
      fails++;
      $display("FAIL enter_run: valid=%b ready=%b, want valid=1 ready=0",
               bus.o_w_valid, bus.o_load_ready);
    end
    t = 0;
  endtask

  // Advance rounds [start, stop) with random enable; checks W[t] every cycle
  task automatic run_rounds(input int start, input int stop, input int en_pct);
    int cyc = 0;
    bit en;
    t = start;
    while (t < stop && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (bus.o_w_valid !== 1'b1 || bus.o_w !== exp_w[t] || bus.o_load_ready !== 1'b0 ||
          bus.o_sched_done !== 1'b0 || bus.o_round_err !== exp_err) begin
        fails++;
        $display("FAIL w_t%0d: valid=%b w=%h ready=%b done=%b err=%b, want valid=1 w=%h ready=0 done=0 err=%b",
                 t, bus.o_w_valid, bus.o_w, bus.o_load_ready, bus.o_sched_done,
                 bus.o_round_err, exp_w[t], exp_err);
      end
      en = ($urandom_range(99) < en_pct);
      bus.i_cnt_en     = en;
      bus.i_count      = 6'(t);
      bus.i_load_valid = $urandom_range(1);
      bus.i_load_word  = $urandom;
      #1;
      if (en) t++;
    end
    checks++;
    if (t < stop) begin
      fails++;
      $display("FAIL run_timeout: t=%0d, want %0d", t, stop);
    end
  endtask

  // After the 64th advance: one DONE cycle, then LOAD
  task automatic finish_block();
    @(negedge clk);
    bus.i_cnt_en     = 1'b0;
    bus.i_load_valid = 1'b0;
    checks++;
    if (bus.o_sched_done !== 1'b1 || bus.o_w_valid !== 1'b0 || bus.o_load_ready !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done=%b valid=%b ready=%b, want done=1 valid=0 ready=0",
               bus.o_sched_done, bus.o_w_valid, bus.o_load_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.o_sched_done !== 1'b0 || bus.o_load_ready !== 1'b1 || bus.o_round_err !== exp_err) begin
      fails++;
      $display("FAIL after_done: done=%b ready=%b err=%b, want done=0 ready=1 err=%b",
               bus.o_sched_done, bus.o_load_ready, bus.o_round_err, exp_err);
    end
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    bus.i_load_valid = 1'b0;
    bus.i_load_word  = '0;
    bus.i_cnt_en     = 1'b0;
    bus.i_count      = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_load_ready !== 1'b0 || bus.o_w_valid !== 1'b0 || bus.o_w !== 32'h0 ||
        bus.o_sched_done !== 1'b0 || bus.o_round_err !== 1'b0) begin
      fails++;
      $display("FAIL in_reset: ready=%b valid=%b w=%h done=%b err=%b, want all 0",
               bus.o_load_ready, bus.o_w_valid, bus.o_w, bus.o_sched_done, bus.o_round_err);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.o_load_ready !== 1'b1 || bus.o_w_valid !== 1'b0 || bus.o_sched_done !== 1'b0 ||
        bus.o_round_err !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: ready=%b valid=%b done=%b err=%b, want 1 0 0 0",
               bus.o_load_ready, bus.o_w_valid, bus.o_sched_done, bus.o_round_err);
    end
  endtask

  task automatic test_abc();
    set_abc();
    load_block(100);
    checks++;
    if (bus.o_w !== 32'h61626380) begin
      fails++;
      $display("FAIL abc_w0: got %h, want 61626380", bus.o_w);
    end
    run_rounds(0, 16, 100);
    @(negedge clk);
    bus.i_cnt_en = 1'b0;
    checks++;
    if (bus.o_w !== 32'h61626380) begin
      fails++;
      $display("FAIL abc_w16: got %h, want 61626380", bus.o_w);
    end
    run_rounds(16, 17, 100);
    @(negedge clk);
    bus.i_cnt_en = 1'b0;
    checks++;
    if (bus.o_w !== 32'h000F0000) begin
      fails++;
      $display("FAIL abc_w17: got %h, want 000f0000", bus.o_w);
    end
    run_rounds(17, 64, 100);
    finish_block();
  endtask

  task automatic test_backpressure();
    set_random();
    load_block(40);
    run_rounds(0, 10, 100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_w !== exp_w[10] || bus.o_w_valid !== 1'b1) begin
        fails++;
        $display("FAIL idle_hold%0d: w=%h valid=%b, want w=%h valid=1", i, bus.o_w, bus.o_w_valid, exp_w[10]);
      end
      bus.i_cnt_en     = 1'b0;
      bus.i_load_valid = 1'b1;
      bus.i_load_word  = $urandom;
    end
    run_rounds(10, 64, 60);
    finish_block();
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 2; b++) begin
      set_random();
      load_block(100);
      run_rounds(0, 64, 100);
      finish_block();
    end
  endtask

  task automatic test_mid_reset();
    set_abc();
    load_block(100);
    run_rounds(0, 30, 100);
    @(negedge clk);
    bus.i_cnt_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.o_load_ready !== 1'b0 || bus.o_w_valid !== 1'b0 || bus.o_w !== 32'h0 ||
        bus.o_sched_done !== 1'b0 || bus.o_round_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: ready=%b valid=%b w=%h done=%b err=%b, want 0 0 0 0 0",
               bus.o_load_ready, bus.o_w_valid, bus.o_w, bus.o_sched_done, bus.o_round_err);
    end
    exp_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_cnt_en = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.o_sched_done !== 1'b0 || bus.o_load_ready !== 1'b1 || bus.o_w_valid !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle%0d: done=%b ready=%b valid=%b, want 0 1 0",
                 i, bus.o_sched_done, bus.o_load_ready, bus.o_w_valid);
      end
    end
    bus.i_cnt_en = 1'b0;
    load_block(100);
    run_rounds(0, 64, 100);
    finish_block();
  endtask

  task automatic test_round_chk();
    set_random();
    load_block(100);
    run_rounds(0, 4, 100);
    @(negedge clk);
    bus.i_cnt_en     = 1'b1;
    bus.i_count      = 6'd5;
    bus.i_load_valid = 1'b0;
`ifdef ROUND_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #1;
    run_rounds(5, 64, 80);
    finish_block();
    set_random();
    load_block(70);
    run_rounds(0, 64, 100);
    finish_block();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_round_chk();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
